// File: rtl/riscv_datapath_pkg.sv
// ============================================================================
// Module   : riscv_dp_pkg
// Brief    : Shared constants for the RV32I multicycle datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_dp_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    function automatic word_t signExt13(input logic [12:0] v);
        return {{(XLEN-13){v[12]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_datapath_if.sv
// ============================================================================
// Module   : riscv_datapath_if
// Brief    : Control, instruction and memory bus between FSM/memories and datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_datapath_if;
    import riscv_dp_pkg::*;

    word_t       instr;
    word_t       dReadData;
    logic        loadPC;
    logic        PCSrc;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        MemToReg;
    logic        RegWrite;
    word_t       PC;
    word_t       dAddress;
    word_t       dWriteData;
    word_t       WriteBackData;
    logic        Zero;

    modport master (
        output instr, dReadData, loadPC, PCSrc, ALUSrc, ALUCtrl, MemToReg, RegWrite,
        input  PC, dAddress, dWriteData, WriteBackData, Zero
    );

    modport slave (
        input  instr, dReadData, loadPC, PCSrc, ALUSrc, ALUCtrl, MemToReg, RegWrite,
        output PC, dAddress, dWriteData, WriteBackData, Zero
    );

endinterface

`default_nettype wire

// File: rtl/riscv_datapath_regfile.sv
// ============================================================================
// Module   : riscv_regfile
// Brief    : 32x32 register file, two async read ports, one sync write port.
//            Optional macro RF_CLEAR_ON_RESET_EN clears x1..x31 on reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_regfile
    import riscv_dp_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [4:0] i_rs1Addr,
    input  wire logic [4:0] i_rs2Addr,
    input  wire logic [4:0] i_rdAddr,
    input  wire logic       i_we,
    input  wire word_t      i_wdata,
    output word_t           o_rs1Data,
    output word_t           o_rs2Data
);

    // Entry 0 is never written; reads of x0 are forced to zero below.
    word_t r_regs [0:31];

`ifdef RF_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_rdAddr != 5'd0)) begin
            r_regs[i_rdAddr] <= i_wdata;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst && i_we && (i_rdAddr != 5'd0)) begin
            r_regs[i_rdAddr] <= i_wdata;
        end
    end
`endif

    assign o_rs1Data = (i_rs1Addr == 5'd0) ? '0 : r_regs[i_rs1Addr];
    assign o_rs2Data = (i_rs2Addr == 5'd0) ? '0 : r_regs[i_rs2Addr];

endmodule

`default_nettype wire

// File: rtl/riscv_datapath.sv
// ============================================================================
// Module   : riscv_datapath
// Brief    : RV32I multicycle datapath: PC, regfile, imm gen, ALU, write-back.
//            Optional macro RF_CLEAR_ON_RESET_EN (see riscv_regfile).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_datapath
    import riscv_dp_pkg::*;
#(
    parameter word_t INITIAL_PC = 32'h00400000
)
(
    input  wire logic          clk,
    input  wire logic          rst,
    riscv_datapath_if.slave    dp
);

    word_t      r_pc;
    word_t      w_rs1Data;
    word_t      w_rs2Data;
    word_t      w_imm;
    word_t      w_immB;
    word_t      w_aluB;
    word_t      w_aluResult;
    word_t      w_writeBack;
    logic [4:0] w_shamt;

    riscv_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_rs1Addr (dp.instr[19:15]),
        .i_rs2Addr (dp.instr[24:20]),
        .i_rdAddr  (dp.instr[11:7]),
        .i_we      (dp.RegWrite),
        .i_wdata   (w_writeBack),
        .o_rs1Data (w_rs1Data),
        .o_rs2Data (w_rs2Data)
    );

    always_comb begin
        w_imm = '0;
        case (dp.instr[6:0])
            OP_LOAD, OP_IMM: w_imm = signExt13({dp.instr[31], dp.instr[31:20]});
            OP_STORE:        w_imm = signExt13({dp.instr[31], dp.instr[31:25], dp.instr[11:7]});
            OP_BRANCH:       w_imm = w_immB;
            default:         w_imm = '0;
        endcase
    end

    // Branch offset is decoded independently of the opcode so PCSrc alone selects the target.
    assign w_immB = signExt13({dp.instr[31], dp.instr[7], dp.instr[30:25], dp.instr[11:8], 1'b0});

    assign w_aluB  = dp.ALUSrc ? w_imm : w_rs2Data;
    assign w_shamt = w_aluB[4:0];

    always_comb begin
        w_aluResult = '0;
        case (dp.ALUCtrl)
            ALU_AND: w_aluResult = w_rs1Data & w_aluB;
            ALU_OR:  w_aluResult = w_rs1Data | w_aluB;
            ALU_ADD: w_aluResult = w_rs1Data + w_aluB;
            ALU_SUB: w_aluResult = w_rs1Data - w_aluB;
            ALU_XOR: w_aluResult = w_rs1Data ^ w_aluB;
            ALU_SLT: w_aluResult = {{(XLEN-1){1'b0}}, ($signed(w_rs1Data) < $signed(w_aluB))};
            ALU_SLL: w_aluResult = w_rs1Data << w_shamt;
            ALU_SRL: w_aluResult = w_rs1Data >> w_shamt;
            ALU_SRA: w_aluResult = word_t'($signed(w_rs1Data) >>> w_shamt);
            default: w_aluResult = '0;
        endcase
    end

    assign w_writeBack = dp.MemToReg ? dp.dReadData : w_aluResult;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= INITIAL_PC;
        end else if (dp.loadPC) begin
            r_pc <= dp.PCSrc ? (r_pc + w_immB) : (r_pc + 32'd4);
        end
    end

    assign dp.PC            = r_pc;
    assign dp.dAddress      = w_aluResult;
    assign dp.dWriteData    = w_rs2Data;
    assign dp.WriteBackData = w_writeBack;
    assign dp.Zero          = (w_aluResult == '0);

endmodule

`default_nettype wire

// File: tb/tb_riscv_datapath.sv
// ============================================================================
// Module   : tb_riscv_datapath
// Brief    : Directed plus randomized self-checking bench for riscv_datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_datapath;

    localparam logic [31:0] INIT = 32'h00400000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_datapath_if dpIf ();

    riscv_datapath #(.INITIAL_PC(INIT)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dpIf)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mRf [32];
    logic [31:0] mPc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refImm(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011, 7'b0010011: return {{20{ins[31]}}, ins[31:20]};
            7'b0100011:             return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            7'b1100011:             return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default:                return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] refBranchOff(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] refAlu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        case (ctrl)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a + ~b + 32'd1;
            4'b0101: return a ^ b;
            4'b0100: begin
                if (a[31] != b[31]) return {31'b0, a[31]};
                else                return {31'b0, (a < b)};
            end
            4'b1001: return a << b[4:0];
            4'b1000: return a >> b[4:0];
            4'b1010: return a[31] ? ~((~a) >> b[4:0]) : (a >> b[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] rdData, input logic lpc,
                         input logic psrc, input logic asrc, input logic [3:0] ctrl,
                         input logic m2r, input logic rw, input logic rstAct);
        dpIf.instr     = ins;
        dpIf.dReadData = rdData;
        dpIf.loadPC    = lpc;
        dpIf.PCSrc     = psrc;
        dpIf.ALUSrc    = asrc;
        dpIf.ALUCtrl   = ctrl;
        dpIf.MemToReg  = m2r;
        dpIf.RegWrite  = rw;
        rst            = rstAct ? 1'b0 : 1'b1;
    endtask

    // One clocked step: check combinational outputs against the model, clock, update model, check PC.
    task automatic step(input logic [31:0] ins, input logic [31:0] rdData, input logic lpc,
                        input logic psrc, input logic asrc, input logic [3:0] ctrl,
                        input logic m2r, input logic rw, input logic rstAct);
        logic [31:0] a, b, res, wb;
        @(negedge clk);
        drive(ins, rdData, lpc, psrc, asrc, ctrl, m2r, rw, rstAct);
        #1;
        a   = mRf[ins[19:15]];
        b   = asrc ? refImm(ins) : mRf[ins[24:20]];
        res = refAlu(ctrl, a, b);
        wb  = m2r ? rdData : res;
        chk("dAddress", dpIf.dAddress, res);
        chk("dWriteData", dpIf.dWriteData, mRf[ins[24:20]]);
        chk("WriteBackData", dpIf.WriteBackData, wb);
        chk("Zero", {31'b0, dpIf.Zero}, {31'b0, (res == 32'h0)});
        @(posedge clk);
        if (rstAct) begin
            mPc = INIT;
`ifdef RF_CLEAR_ON_RESET_EN
            for (int i = 1; i < 32; i++) mRf[i] = 32'h0;
`endif
        end else begin
            if (lpc) mPc = psrc ? (mPc + refBranchOff(ins)) : (mPc + 32'd4);
            if (rw && (ins[11:7] != 5'd0)) mRf[ins[11:7]] = wb;
        end
        #1;
        chk("PC", dpIf.PC, mPc);
    endtask

    // Apply inputs with no state change and let them settle for a constant check.
    task automatic probe(input logic [31:0] ins, input logic [31:0] rdData, input logic asrc,
                         input logic [3:0] ctrl, input logic m2r);
        @(negedge clk);
        drive(ins, rdData, 1'b0, 1'b0, asrc, ctrl, m2r, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        logic [31:0] ins;
        logic        rstNow;
        for (int i = 0; i < 32; i++) mRf[i] = (i == 0) ? 32'h0 : 32'hx;
        mPc = 32'hx;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset overrides loadPC, then PC holds without loadPC
        step(32'h00000013, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1);
        chk("pc_reset", dpIf.PC, 32'h00400000);
        step(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("pc_hold", dpIf.PC, 32'h00400000);

        // Sequential PC and a +16 branch
        for (int i = 0; i < 3; i++)
            step(32'h00000013, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("pc_plus12", dpIf.PC, 32'h0040000C);
        step(32'h00000863, 32'h0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
        chk("pc_branch16", dpIf.PC, 32'h0040001C);

        // addi x1,x0,5 then sub x2,x1,x1
        step(32'h00500093, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
        probe(32'h00100033, 32'h0, 1'b0, 4'b0010, 1'b0);
        chk("addi_x1", dpIf.dWriteData, 32'd5);
        step(32'h40108133, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0);
        chk("sub_result", dpIf.dAddress, 32'h0);
        chk("sub_zero", {31'b0, dpIf.Zero}, 32'd1);

        // Shifts, SLT and an undefined ALU code with x1=0xFFFFFFF0, x2=4
        step(32'h00000083, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0);
        step(32'h00400113, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
        probe(32'h00208033, 32'h0, 1'b0, 4'b1010, 1'b0);
        chk("sra", dpIf.dAddress, 32'hFFFFFFFF);
        probe(32'h00208033, 32'h0, 1'b0, 4'b1000, 1'b0);
        chk("srl", dpIf.dAddress, 32'h0FFFFFFF);
        probe(32'h00208033, 32'h0, 1'b0, 4'b0100, 1'b0);
        chk("slt", dpIf.dAddress, 32'd1);
        probe(32'h00208033, 32'h0, 1'b0, 4'b1111, 1'b0);
        chk("alu_undef", dpIf.dAddress, 32'h0);
        chk("alu_undef_zero", {31'b0, dpIf.Zero}, 32'd1);

        // Store addressing and load write-back
        probe(32'h00102423, 32'h0, 1'b1, 4'b0010, 1'b0);
        chk("sw_addr", dpIf.dAddress, 32'd8);
        chk("sw_data", dpIf.dWriteData, 32'hFFFFFFF0);
        step(32'h00002183, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        probe(32'h00300033, 32'h0, 1'b0, 4'b0010, 1'b0);
        chk("lw_x3", dpIf.dWriteData, 32'hCAFEF00D);

        // x0 ignores writes; reset behaviour of x1
        step(32'h00002003, 32'h00001234, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        probe(32'h00000033, 32'h0, 1'b0, 4'b0010, 1'b0);
        chk("x0_zero", dpIf.dWriteData, 32'h0);
        step(32'h00000013, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1);
        probe(32'h00100033, 32'h0, 1'b0, 4'b0010, 1'b0);
`ifdef RF_CLEAR_ON_RESET_EN
        chk("x1_after_reset", dpIf.dWriteData, 32'h0);
`else
        chk("x1_after_reset", dpIf.dWriteData, 32'hFFFFFFF0);
`endif

        // Load every writable register with a random value so the model knows them all
        for (int r = 1; r < 32; r++) begin
            ins = {12'h0, 5'd0, 3'b010, r[4:0], 7'b0000011};
            step(ins, $urandom, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        end

        // Randomized instructions and controls, with occasional mid-stream resets
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0: ins[6:0] = 7'b0000011;
                1: ins[6:0] = 7'b0010011;
                2: ins[6:0] = 7'b0100011;
                3: ins[6:0] = 7'b1100011;
                4: ins[6:0] = 7'b0110011;
                default: ;
            endcase
            rstNow = ($urandom_range(0, 31) == 0);
            step(ins, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), rstNow);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
